// File: rtl/mips_fwd_defs.sv
// Shared forwarding definitions: select codes, shadow-entry layout and its bubble value.
// The operand muxes import this package too, so both sides agree on the codes.
package mips_fwd_defs;

  localparam int unsigned NBITS_REG         = 5;
  localparam int unsigned FWD_SEL_W         = 3;
  localparam int unsigned NBITS_CNT_DEFAULT = 32;

  typedef logic [FWD_SEL_W-1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REG   = 3'b000;
  localparam fwd_sel_t FWD_EXMEM = 3'b001;
  localparam fwd_sel_t FWD_MEMWB = 3'b010;

  typedef struct packed {
    logic [NBITS_REG-1:0] dest;
    logic                 regwrite;
    logic                 memread;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '{dest: '0, regwrite: 1'b0, memread: 1'b0};

  function automatic shadow_t make_entry(input logic [NBITS_REG-1:0] dest,
                                         input logic                 regwrite,
                                         input logic                 memread);
    shadow_t e;
    e.dest     = dest;
    e.regwrite = regwrite;
    e.memread  = memread;
    return e;
  endfunction

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-stage request fields and forwarding/hazard responses between datapath and unit.
// The shadow views expose the EX/MEM and MEM/WB destination info for trace/debug.
interface forwarding_hazard_unit_if #(
  parameter int unsigned NBITS_CNT = mips_fwd_defs::NBITS_CNT_DEFAULT
);
  import mips_fwd_defs::*;

  logic [NBITS_REG-1:0] i_id_rs;
  logic [NBITS_REG-1:0] i_id_rt;
  logic                 i_id_use_rs;
  logic                 i_id_use_rt;
  logic [NBITS_REG-1:0] i_id_dest;
  logic                 i_id_regwrite;
  logic                 i_id_memread;

  fwd_sel_t             o_corto_circuito_rega;
  fwd_sel_t             o_corto_circuito_regb;
  logic                 o_stall;
  logic                 o_bubble_idex;
  logic [NBITS_CNT-1:0] o_stall_count;
  logic [NBITS_CNT-1:0] o_fwd_count;
  shadow_t              o_exmem_shadow;
  shadow_t              o_memwb_shadow;

  modport master (
    output i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
           i_id_dest, i_id_regwrite, i_id_memread,
    input  o_corto_circuito_rega, o_corto_circuito_regb, o_stall, o_bubble_idex,
           o_stall_count, o_fwd_count, o_exmem_shadow, o_memwb_shadow
  );

  modport slave (
    input  i_id_rs, i_id_rt, i_id_use_rs, i_id_use_rt,
           i_id_dest, i_id_regwrite, i_id_memread,
    output o_corto_circuito_rega, o_corto_circuito_regb, o_stall, o_bubble_idex,
           o_stall_count, o_fwd_count, o_exmem_shadow, o_memwb_shadow
  );

endinterface

// File: rtl/fwd_shadow_stage.sv
// One pipeline shadow entry {dest, regwrite, memread}: holds when disabled,
// loads either the incoming entry or a bubble when enabled.
module fwd_shadow_stage
  import mips_fwd_defs::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    load_bubble,
  input  shadow_t d,
  output shadow_t q
);

  shadow_t entry_q;
  shadow_t entry_d;

  always_comb begin
    entry_d = entry_q;
    if (en) begin
      entry_d = load_bubble ? SHADOW_BUBBLE : d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= SHADOW_BUBBLE;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign q = entry_q;

endmodule

// File: rtl/forwarding_hazard_unit.sv
// Operand-forwarding select generator and load-use stall/bubble control for the 5-stage MIPS pipe.
// Optional statistics counters are built only when FWD_STATS_EN is defined.
module forwarding_hazard_unit #(
  parameter int unsigned NBITS_REG     = mips_fwd_defs::NBITS_REG,
  parameter int unsigned CORTOCIRCUITO = mips_fwd_defs::FWD_SEL_W,
  parameter int unsigned NBITS_CNT     = mips_fwd_defs::NBITS_CNT_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_enable,
  input  logic                     i_flush,
  forwarding_hazard_unit_if.slave  fwd
);

  import mips_fwd_defs::shadow_t;
  import mips_fwd_defs::make_entry;
  import mips_fwd_defs::FWD_REG;
  import mips_fwd_defs::FWD_EXMEM;
  import mips_fwd_defs::FWD_MEMWB;

  logic [NBITS_REG-1:0]     rs_c;
  logic [NBITS_REG-1:0]     rt_c;
  shadow_t                  id_entry_c;
  shadow_t                  s1_q;
  shadow_t                  s2_q;
  shadow_t                  s3_q;
  logic                     load_use_c;
  logic                     kill_id_c;
  logic                     stall_c;
  logic                     bubble_c;
  logic [CORTOCIRCUITO-1:0] code_a_q;
  logic [CORTOCIRCUITO-1:0] code_a_d;
  logic [CORTOCIRCUITO-1:0] code_b_q;
  logic [CORTOCIRCUITO-1:0] code_b_d;

  // S1 result reaches EX/MEM next cycle, S2 result reaches MEM/WB; nearer producer wins.
  function automatic logic [CORTOCIRCUITO-1:0] pick_code(input logic                 use_src,
                                                         input logic [NBITS_REG-1:0] src,
                                                         input shadow_t              near,
                                                         input shadow_t              far);
    pick_code = CORTOCIRCUITO'(FWD_REG);
    if (use_src && (src != '0)) begin
      if (near.regwrite && (near.dest == src)) begin
        pick_code = CORTOCIRCUITO'(FWD_EXMEM);
      end else if (far.regwrite && (far.dest == src)) begin
        pick_code = CORTOCIRCUITO'(FWD_MEMWB);
      end
    end
  endfunction

  assign rs_c       = fwd.i_id_rs;
  assign rt_c       = fwd.i_id_rt;
  assign id_entry_c = make_entry(fwd.i_id_dest, fwd.i_id_regwrite, fwd.i_id_memread);

  // Load in EX whose result the ID instruction needs: not forwardable yet.
  assign load_use_c = s1_q.memread && s1_q.regwrite && (s1_q.dest != '0) &&
                      ((fwd.i_id_use_rs && (rs_c == s1_q.dest)) ||
                       (fwd.i_id_use_rt && (rt_c == s1_q.dest)));

  assign kill_id_c = load_use_c || i_flush;
  assign stall_c   = i_reset_n && i_enable && load_use_c && !i_flush;
  assign bubble_c  = i_reset_n && i_enable && kill_id_c;

  fwd_shadow_stage u_s1 (
    .clk         (i_clk),
    .rst_n       (i_reset_n),
    .en          (i_enable),
    .load_bubble (kill_id_c),
    .d           (id_entry_c),
    .q           (s1_q)
  );

  fwd_shadow_stage u_s2 (
    .clk         (i_clk),
    .rst_n       (i_reset_n),
    .en          (i_enable),
    .load_bubble (1'b0),
    .d           (s1_q),
    .q           (s2_q)
  );

  fwd_shadow_stage u_s3 (
    .clk         (i_clk),
    .rst_n       (i_reset_n),
    .en          (i_enable),
    .load_bubble (1'b0),
    .d           (s2_q),
    .q           (s3_q)
  );

  // Select codes for the instruction entering EX on the next edge.
  always_comb begin
    code_a_d = code_a_q;
    code_b_d = code_b_q;
    if (i_enable) begin
      if (kill_id_c) begin
        code_a_d = CORTOCIRCUITO'(FWD_REG);
        code_b_d = CORTOCIRCUITO'(FWD_REG);
      end else begin
        code_a_d = pick_code(fwd.i_id_use_rs, rs_c, s1_q, s2_q);
        code_b_d = pick_code(fwd.i_id_use_rt, rt_c, s1_q, s2_q);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      code_a_q <= CORTOCIRCUITO'(FWD_REG);
      code_b_q <= CORTOCIRCUITO'(FWD_REG);
    end else begin
      code_a_q <= code_a_d;
      code_b_q <= code_b_d;
    end
  end

`ifdef FWD_STATS_EN
  logic [NBITS_CNT-1:0] stall_count_q;
  logic [NBITS_CNT-1:0] stall_count_d;
  logic [NBITS_CNT-1:0] fwd_count_q;
  logic [NBITS_CNT-1:0] fwd_count_d;

  // Wrapping counters; forwarded operands counted as the codes are loaded.
  always_comb begin
    stall_count_d = stall_count_q;
    fwd_count_d   = fwd_count_q;
    if (i_enable) begin
      stall_count_d = stall_count_q + NBITS_CNT'(stall_c);
      fwd_count_d   = fwd_count_q + NBITS_CNT'(code_a_d != '0) + NBITS_CNT'(code_b_d != '0);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_count_q <= '0;
      fwd_count_q   <= '0;
    end else begin
      stall_count_q <= stall_count_d;
      fwd_count_q   <= fwd_count_d;
    end
  end

  assign fwd.o_stall_count = stall_count_q;
  assign fwd.o_fwd_count   = fwd_count_q;
`else
  assign fwd.o_stall_count = NBITS_CNT'(0);
  assign fwd.o_fwd_count   = NBITS_CNT'(0);
`endif

  assign fwd.o_corto_circuito_rega = code_a_q;
  assign fwd.o_corto_circuito_regb = code_b_q;
  assign fwd.o_stall               = stall_c;
  assign fwd.o_bubble_idex         = bubble_c;
  assign fwd.o_exmem_shadow        = s2_q;
  assign fwd.o_memwb_shadow        = s3_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed vector bench for forwarding_hazard_unit: instruction-stream table plus
// hand sequences for reset-during-stall and the statistics counters.
module tb_forwarding_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        flush;
  int unsigned n_vec;
  int unsigned n_fail;

  forwarding_hazard_unit_if #(.NBITS_CNT(32)) bus ();

  forwarding_hazard_unit #(
    .NBITS_REG     (5),
    .CORTOCIRCUITO (3),
    .NBITS_CNT     (32)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_enable  (en),
    .i_flush   (flush),
    .fwd       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] dest;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       en;
    logic       x_stall;
    logic       x_bub;
    logic [2:0] xa;
    logic [2:0] xb;
  } vec_t;

  vec_t tbl[$];

  task automatic add_v(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt,
                       input logic [4:0] dest, input logic rw, input logic mr,
                       input logic fl, input logic e,
                       input logic xs, input logic xbub,
                       input logic [2:0] xa, input logic [2:0] xb);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.dest = dest; v.rw = rw; v.mr = mr; v.fl = fl; v.en = e;
    v.x_stall = xs; v.x_bub = xbub; v.xa = xa; v.xb = xb;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_id_rs       = v.rs;
    bus.i_id_rt       = v.rt;
    bus.i_id_use_rs   = v.urs;
    bus.i_id_use_rt   = v.urt;
    bus.i_id_dest     = v.dest;
    bus.i_id_regwrite = v.rw;
    bus.i_id_memread  = v.mr;
    en                = v.en;
    flush             = v.fl;
  endtask

  task automatic drive_instr(input logic [4:0] rs, input logic [4:0] rt,
                             input logic urs, input logic urt,
                             input logic [4:0] dest, input logic rw, input logic mr);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.dest = dest; v.rw = rw; v.mr = mr; v.fl = 1'b0; v.en = 1'b1;
    v.x_stall = 1'b0; v.x_bub = 1'b0; v.xa = 3'b000; v.xb = 3'b000;
    drive(v);
  endtask

  task automatic chk_codes(input string tag, input logic [2:0] xa, input logic [2:0] xb);
    chk({tag, " code_a"}, 32'(bus.o_corto_circuito_rega), 32'(xa));
    chk({tag, " code_b"}, 32'(bus.o_corto_circuito_regb), 32'(xb));
  endtask

  task automatic chk_ctl(input string tag, input logic xs, input logic xbub);
    chk({tag, " stall"},  32'(bus.o_stall),       32'(xs));
    chk({tag, " bubble"}, 32'(bus.o_bubble_idex), 32'(xbub));
  endtask

  logic [31:0] exp_stall_cnt;
  logic [31:0] exp_fwd_cnt;

  initial begin
    n_vec  = 0;
    n_fail = 0;
`ifdef FWD_STATS_EN
    exp_stall_cnt = 32'd1;
    exp_fwd_cnt   = 32'd2;
`else
    exp_stall_cnt = 32'd0;
    exp_fwd_cnt   = 32'd0;
`endif

    // rs, rt, urs, urt, dest, rw, mr, fl, en | stall, bubble, code_a, code_b
    add_v(1,  2,  1, 1, 3,  1, 0, 0, 1,  0, 0, 3'b000, 3'b000); // add $3,$1,$2
    add_v(3,  5,  1, 1, 4,  1, 0, 0, 1,  0, 0, 3'b001, 3'b000); // sub $4,$3,$5
    add_v(0,  0,  0, 0, 0,  0, 0, 0, 1,  0, 0, 3'b000, 3'b000); // nop
    add_v(1,  2,  1, 1, 3,  1, 0, 0, 1,  0, 0, 3'b000, 3'b000); // add $3
    add_v(0,  0,  0, 0, 0,  0, 0, 0, 1,  0, 0, 3'b000, 3'b000); // nop
    add_v(7,  3,  1, 1, 6,  1, 0, 0, 1,  0, 0, 3'b000, 3'b010); // or $6,$7,$3 dist 2
    add_v(1,  2,  1, 1, 3,  1, 0, 0, 1,  0, 0, 3'b000, 3'b000); // add $3
    add_v(3,  3,  1, 0, 3,  1, 0, 0, 1,  0, 0, 3'b001, 3'b000); // addi $3,$3,1
    add_v(7,  3,  1, 1, 6,  1, 0, 0, 1,  0, 0, 3'b000, 3'b001); // or: nearer writer wins
    add_v(1,  0,  1, 0, 0,  1, 0, 0, 1,  0, 0, 3'b000, 3'b000); // addi $0,$1,5
    add_v(0,  0,  1, 1, 10, 1, 0, 0, 1,  0, 0, 3'b000, 3'b000); // add $10,$0,$0
    add_v(0,  0,  1, 1, 11, 1, 0, 0, 1,  0, 0, 3'b000, 3'b000); // add $11,$0,$0
    add_v(1,  8,  1, 0, 8,  1, 1, 0, 1,  0, 0, 3'b000, 3'b000); // lw $8,0($1)
    add_v(8,  8,  1, 1, 9,  1, 0, 0, 1,  1, 1, 3'b000, 3'b000); // add $9,$8,$8 stall
    add_v(8,  8,  1, 1, 9,  1, 0, 0, 1,  0, 0, 3'b010, 3'b010); // held add re-evaluated
    add_v(0,  0,  0, 0, 0,  0, 0, 0, 1,  0, 0, 3'b000, 3'b000); // nop
    add_v(1,  0,  1, 0, 0,  1, 1, 0, 1,  0, 0, 3'b000, 3'b000); // lw $0
    add_v(0,  0,  1, 1, 12, 1, 0, 0, 1,  0, 0, 3'b000, 3'b000); // reader of $0: no stall
    add_v(1,  8,  1, 0, 8,  1, 1, 0, 1,  0, 0, 3'b000, 3'b000); // lw $8
    add_v(8,  8,  1, 1, 9,  1, 0, 1, 1,  0, 1, 3'b000, 3'b000); // hazard + flush
    add_v(8,  0,  1, 0, 13, 1, 0, 0, 1,  0, 0, 3'b010, 3'b000); // sub $13,$8,$0
    add_v(13, 13, 1, 1, 15, 1, 0, 0, 0,  0, 0, 3'b010, 3'b000); // disabled: hold
    add_v(13, 13, 1, 1, 15, 1, 0, 1, 0,  0, 0, 3'b010, 3'b000); // disabled flush ignored
    add_v(13, 13, 1, 1, 15, 1, 0, 0, 0,  0, 0, 3'b010, 3'b000); // disabled: hold
    add_v(13, 13, 1, 1, 15, 1, 0, 0, 1,  0, 0, 3'b001, 3'b001); // resumes
    add_v(15, 8,  1, 0, 8,  1, 1, 0, 1,  0, 0, 3'b001, 3'b000); // lw $8,0($15)
    add_v(8,  8,  1, 1, 9,  1, 0, 0, 0,  0, 0, 3'b001, 3'b000); // hazard while disabled
    add_v(8,  8,  1, 1, 9,  1, 0, 0, 1,  1, 1, 3'b000, 3'b000); // stall
    add_v(8,  8,  1, 1, 9,  1, 0, 0, 1,  0, 0, 3'b010, 3'b010); // forwarded

    // Reset with flush asserted: everything must read idle.
    rst_n = 1'b1;
    en    = 1'b1;
    flush = 1'b0;
    drive_instr(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    flush = 1'b1;
    #1;
    chk_codes("reset", 3'b000, 3'b000);
    chk_ctl("reset", 1'b0, 1'b0);
    chk("reset stall_count", bus.o_stall_count, 32'd0);
    chk("reset fwd_count",   bus.o_fwd_count,   32'd0);
    repeat (2) @(negedge clk);
    flush = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk_ctl($sformatf("v%0d", i), tbl[i].x_stall, tbl[i].x_bub);
      @(posedge clk);
      #1;
      chk_codes($sformatf("v%0d", i), tbl[i].xa, tbl[i].xb);
    end

    // lw $8,0($9) forwards $9 from the add still in EX.
    @(negedge clk);
    drive_instr(9, 8, 1, 0, 8, 1, 1);
    @(posedge clk);
    #1;
    chk_codes("midrst lw", 3'b001, 3'b000);

    // Reset while the dependent add is stalled.
    @(negedge clk);
    drive_instr(8, 8, 1, 1, 9, 1, 0);
    #1;
    chk_ctl("midrst pre", 1'b1, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_codes("midrst async", 3'b000, 3'b000);
    chk_ctl("midrst async", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_ctl("midrst post", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_codes("midrst post", 3'b000, 3'b000);

    // Clean load-use after reset for the statistics counters.
    @(negedge clk);
    drive_instr(1, 8, 1, 0, 8, 1, 1);
    @(posedge clk);
    #1;
    chk_codes("stats lw", 3'b000, 3'b000);
    @(negedge clk);
    drive_instr(8, 8, 1, 1, 9, 1, 0);
    #1;
    chk_ctl("stats stall", 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk_codes("stats stall", 3'b000, 3'b000);
    @(negedge clk);
    #1;
    chk_ctl("stats after", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_codes("stats fwd", 3'b010, 3'b010);
    @(negedge clk);
    drive_instr(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("stats stall_count", bus.o_stall_count, exp_stall_cnt);
    chk("stats fwd_count",   bus.o_fwd_count,   exp_fwd_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
